mm_score_engine: RTL
====================

MM_SCORE_ENGINE -- requirements
Module: mm_score_engine

Interface
REQ-001 Parameter NUM_PEGS, default 4: pegs per code/guess (2..8).
REQ-002 Parameter COLOR_W, default 3: bits per peg; NCOL = 2**COLOR_W colours.
REQ-003 Parameter MAX_GUESSES, default 8: guesses before loss.
REQ-004 Derived: CNT_W = clog2(NUM_PEGS+1), GC_W = clog2(MAX_GUESSES+1), VEC_W = NUM_PEGS*COLOR_W.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 code_in  in  VEC_W  secret code; peg i at bits [i*COLOR_W +: COLOR_W], peg 0 in LSBs.
REQ-008 load_code  in  1  latch code_in and start new game.
REQ-009 guess_in  in  VEC_W  guess, same packing as code_in.
REQ-010 start  in  1  request scoring of guess_in.
REQ-011 busy  out  1  high from RED through DONE.
REQ-012 done  out  1  one-cycle pulse, results valid.
REQ-013 red  out  CNT_W  exact position+colour matches.
REQ-014 white  out  CNT_W  colour-only matches, duplicates counted once.
REQ-015 guess_count  out  GC_W  scored guesses this game.
REQ-016 win / lose  out  1 each  sticky game-over flags.

Function
REQ-017 FSM states IDLE, RED, COLOR, DONE; IDLE->RED on accepted start; RED->COLOR after 1 cycle; COLOR->DONE after NCOL cycles; DONE->IDLE after 1 cycle.
REQ-018 start accepted only in IDLE with win=0, lose=0, load_code=0; otherwise ignored, no state change.
REQ-019 On accept, guess_in registered; later guess_in changes do not affect the result.
REQ-020 RED: red_acc = count of i with code[i]==guess[i]; red-match mask stored; white_acc cleared.
REQ-021 COLOR: colour index c steps 0..NCOL-1, one per cycle; white_acc += min(unmasked code pegs == c, unmasked guess pegs == c).
REQ-022 Latency: start sampled on edge k -> done high in cycle after edge k+NCOL+2 (default 10 cycles).
REQ-023 In DONE: red/white outputs updated; guess_count += 1; win set if red==NUM_PEGS; else lose set if new guess_count==MAX_GUESSES; win has priority on final guess.
REQ-024 red/white hold last result until next DONE or load_code; red+white <= NUM_PEGS always.
REQ-025 load_code accepted only in IDLE: latch code, clear red, white, guess_count, win, lose; load_code while busy ignored.
REQ-026 load_code and start both high in IDLE: load_code wins, start dropped.
REQ-027 guess_count saturates at MAX_GUESSES; no wrap.
REQ-028 No arithmetic overflow: accumulators CNT_W wide; colour index wraps only at COLOR->DONE exit.

Reset
REQ-029 resetn low: state=IDLE, busy=0, done=0, red=0, white=0, guess_count=0, win=0, lose=0, code and guess registers zero; takes effect immediately, including mid-COLOR (scoring aborted, no done).

Structure
REQ-030 Package mm_pkg holds the FSM state enum and default values for NUM_PEGS, COLOR_W, MAX_GUESSES.
REQ-031 One combinational sub-module mm_color_count: counts pegs equal to a colour in a masked vector; instantiated twice (code, guess).

Verification
REQ-032 code {1,2,3,4}, guess {1,2,3,4} -> red=4, white=0, win=1, done 10 cycles after start.
REQ-033 code {0,0,1,1}, guess {1,1,0,0} -> red=0, white=4; code {1,1,2,3}, guess {1,1,1,1} -> red=2, white=0.
REQ-034 code {1,2,3,4}, eight guesses {5,5,5,5} -> red=0,white=0 each; lose=1 after 8th; 9th start ignored, guess_count=8.
REQ-035 start pulsed during COLOR and guess_in changed after accept -> single done, result from original guess.
REQ-036 resetn low mid-COLOR -> all outputs zero immediately, no done; load_code+start same cycle -> new game, no scoring.

Source files
------------

// File: rtl/mm_score_engine_pkg.sv
// Shared types and default parameter values for the Mastermind scoring engine.
package mm_pkg;

    localparam int NUM_PEGS_DEF    = 4;
    localparam int COLOR_W_DEF     = 3;
    localparam int MAX_GUESSES_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RED   = 2'd1,
        ST_COLOR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mm_score_engine_if.sv
// Code/guess/result bundle between a game controller (master) and the scorer (slave).
interface mm_score_engine_if
    import mm_pkg::*;
#(
    parameter int NUM_PEGS    = NUM_PEGS_DEF,
    parameter int COLOR_W     = COLOR_W_DEF,
    parameter int MAX_GUESSES = MAX_GUESSES_DEF
);
    localparam int CNT_W = $clog2(NUM_PEGS + 1);
    localparam int GC_W  = $clog2(MAX_GUESSES + 1);
    localparam int VEC_W = NUM_PEGS * COLOR_W;

    logic [VEC_W-1:0] code_in;
    logic             load_code;
    logic [VEC_W-1:0] guess_in;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] red;
    logic [CNT_W-1:0] white;
    logic [GC_W-1:0]  guess_count;
    logic             win;
    logic             lose;

    modport master (
        output code_in, load_code, guess_in, start,
        input  busy, done, red, white, guess_count, win, lose
    );

    modport slave (
        input  code_in, load_code, guess_in, start,
        output busy, done, red, white, guess_count, win, lose
    );

endinterface

// File: rtl/mm_color_count.sv
// Counts pegs of one colour in a packed peg vector, skipping pegs whose mask bit is set.
module mm_color_count
    import mm_pkg::*;
#(
    parameter int NUM_PEGS = NUM_PEGS_DEF,
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int CNT_W    = $clog2(NUM_PEGS + 1)
) (
    input  logic [NUM_PEGS*COLOR_W-1:0] vec,
    input  logic [NUM_PEGS-1:0]         mask,
    input  logic [COLOR_W-1:0]          color,
    output logic [CNT_W-1:0]            count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (!mask[i] && (vec[i*COLOR_W +: COLOR_W] == color))
                count = count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mm_score_engine.sv
// Mastermind scorer: exact matches in one cycle, then colour-only matches swept one colour per cycle.
module mm_score_engine
    import mm_pkg::*;
#(
    parameter int NUM_PEGS    = NUM_PEGS_DEF,
    parameter int COLOR_W     = COLOR_W_DEF,
    parameter int MAX_GUESSES = MAX_GUESSES_DEF
) (
    input logic               clk,
    input logic               resetn,
    mm_score_engine_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_PEGS + 1);
    localparam int GC_W  = $clog2(MAX_GUESSES + 1);
    localparam int VEC_W = NUM_PEGS * COLOR_W;

    state_t              state;
    logic [VEC_W-1:0]    code_q;
    logic [VEC_W-1:0]    guess_q;
    logic [NUM_PEGS-1:0] mask_q;
    logic [CNT_W-1:0]    red_acc;
    logic [CNT_W-1:0]    white_acc;
    logic [COLOR_W-1:0]  col_idx;
    logic [CNT_W-1:0]    red_q;
    logic [CNT_W-1:0]    white_q;
    logic [GC_W-1:0]     guess_cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                win_q;
    logic                lose_q;

    logic [CNT_W-1:0]    red_now;
    logic [NUM_PEGS-1:0] mask_now;
    logic [CNT_W-1:0]    code_cnt;
    logic [CNT_W-1:0]    guess_cnt;
    logic [CNT_W-1:0]    min_cnt;
    logic                load_ok;
    logic                start_ok;

    always_comb begin
        red_now  = '0;
        mask_now = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (code_q[i*COLOR_W +: COLOR_W] == guess_q[i*COLOR_W +: COLOR_W]) begin
                mask_now[i] = 1'b1;
                red_now     = red_now + CNT_W'(1);
            end
        end
    end

    // Exact-match pegs are masked out of both vectors so they never count as white.
    mm_color_count #(.NUM_PEGS(NUM_PEGS), .COLOR_W(COLOR_W), .CNT_W(CNT_W)) u_code_count (
        .vec   (code_q),
        .mask  (mask_q),
        .color (col_idx),
        .count (code_cnt)
    );

    mm_color_count #(.NUM_PEGS(NUM_PEGS), .COLOR_W(COLOR_W), .CNT_W(CNT_W)) u_guess_count (
        .vec   (guess_q),
        .mask  (mask_q),
        .color (col_idx),
        .count (guess_cnt)
    );

    assign min_cnt  = (code_cnt < guess_cnt) ? code_cnt : guess_cnt;
    assign load_ok  = (state == ST_IDLE) && bus.load_code;
    assign start_ok = (state == ST_IDLE) && bus.start && !bus.load_code && !win_q && !lose_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            code_q      <= '0;
            guess_q     <= '0;
            mask_q      <= '0;
            red_acc     <= '0;
            white_acc   <= '0;
            col_idx     <= '0;
            red_q       <= '0;
            white_q     <= '0;
            guess_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_ok) begin
                        code_q      <= bus.code_in;
                        red_q       <= '0;
                        white_q     <= '0;
                        guess_cnt_q <= '0;
                        win_q       <= 1'b0;
                        lose_q      <= 1'b0;
                    end else if (start_ok) begin
                        guess_q <= bus.guess_in;
                        busy_q  <= 1'b1;
                        state   <= ST_RED;
                    end
                end
                ST_RED: begin
                    red_acc   <= red_now;
                    mask_q    <= mask_now;
                    white_acc <= '0;
                    col_idx   <= '0;
                    state     <= ST_COLOR;
                end
                ST_COLOR: begin
                    white_acc <= white_acc + min_cnt;
                    col_idx   <= col_idx + COLOR_W'(1);
                    if (&col_idx)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    red_q   <= red_acc;
                    white_q <= white_acc;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    if (guess_cnt_q != GC_W'(MAX_GUESSES))
                        guess_cnt_q <= guess_cnt_q + GC_W'(1);
                    if (red_acc == CNT_W'(NUM_PEGS))
                        win_q <= 1'b1;
                    else if (guess_cnt_q == GC_W'(MAX_GUESSES - 1))
                        lose_q <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.red         = red_q;
    assign bus.white       = white_q;
    assign bus.guess_count = guess_cnt_q;
    assign bus.win         = win_q;
    assign bus.lose        = lose_q;

endmodule
